// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: registered ALU control decode for the pipelined LEGv8 datapath.
// Decodes ALUOp + opcode into the 3-bit ALU control word held in the ID/EX
// register, honours stall/flush, and sequences a multi-cycle MUL.
// Optional feature macro: ALU_CTRL_MUL_EN (multi-cycle MUL support).
// When the macro is undefined, MUL decodes as illegal and busy is tied low.
module alu_ctrl_pipe #(
  parameter int OPC_W      = 11,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] instr,
  input  logic [1:0]       alu_op,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [2:0]       alu_ctrl,
  output logic             illegal,
  output logic             busy
);

  localparam logic [2:0] C_AND   = 3'b000;
  localparam logic [2:0] C_ORR   = 3'b001;
  localparam logic [2:0] C_ADD   = 3'b010;
  localparam logic [2:0] C_EOR   = 3'b011;
  localparam logic [2:0] C_MUL   = 3'b100;
  localparam logic [2:0] C_SUB   = 3'b110;
  localparam logic [2:0] C_PASSB = 3'b111;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_EOR = 11'b11001010000;
`ifdef ALU_CTRL_MUL_EN
  localparam logic [10:0] OP_MUL = 11'b10011011000;
`endif

  // Elaboration-time parameter sanity check.
  if (OPC_W < 11 || MUL_CYCLES < 1) begin : g_bad_param
    $error("alu_ctrl_pipe: OPC_W must be >= 11 and MUL_CYCLES >= 1");
  end

  logic [10:0] w_opc;
  logic [2:0]  w_dec_ctrl;
  logic        w_dec_ill;
  logic        w_busy;
  logic        w_load;

  logic        r_out_valid;
  logic [2:0]  r_alu_ctrl;
  logic        r_illegal;

  assign w_opc  = instr[OPC_W-1 -: 11];
  assign w_load = in_valid && !stall && !w_busy && !flush;

  // Combinational decode of ALUOp + opcode; alu_op[0] takes priority.
  always_comb begin
    w_dec_ctrl = C_ADD;
    w_dec_ill  = 1'b0;
    if (alu_op[0]) begin
      w_dec_ctrl = C_PASSB;
    end else if (alu_op[1]) begin
      case (w_opc)
        OP_ADD:  w_dec_ctrl = C_ADD;
        OP_SUB:  w_dec_ctrl = C_SUB;
        OP_AND:  w_dec_ctrl = C_AND;
        OP_ORR:  w_dec_ctrl = C_ORR;
        OP_EOR:  w_dec_ctrl = C_EOR;
`ifdef ALU_CTRL_MUL_EN
        OP_MUL:  w_dec_ctrl = C_MUL;
`endif
        default: begin
          w_dec_ctrl = C_ADD;
          w_dec_ill  = 1'b1;
        end
      endcase
    end
  end

  // ID/EX register: flush clears, load captures decode, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_alu_ctrl  <= C_ADD;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_alu_ctrl  <= C_ADD;
      r_illegal   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_alu_ctrl  <= w_dec_ctrl;
      r_illegal   <= w_dec_ill;
    end
  end

`ifdef ALU_CTRL_MUL_EN
  localparam int CW = $clog2(MUL_CYCLES + 1);

  typedef enum logic {
    S_RUN,
    S_MUL
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;

  assign w_busy = (r_state == S_MUL);

  // MUL occupancy FSM: counter runs down regardless of stall; flush aborts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else if (flush) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_load && (w_dec_ctrl == C_MUL) && (MUL_CYCLES > 1)) begin
            r_state <= S_MUL;
            r_cnt   <= CW'(MUL_CYCLES - 1);
          end
        end
        S_MUL: begin
          if (r_cnt <= CW'(1)) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= S_RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end
`else
  assign w_busy = 1'b0;
`endif

  assign busy      = w_busy;
  assign in_ready  = !w_busy;
  assign out_valid = r_out_valid;
  assign alu_ctrl  = r_alu_ctrl;
  assign illegal   = r_illegal;

endmodule
